// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h8000_0000;
    localparam logic [31:0] INST_NOP           = 32'h0000_0013;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 4;
    localparam int unsigned PTR_W_DEFAULT      = $clog2(FIFO_DEPTH_DEFAULT);

    typedef logic [PTR_W_DEFAULT-1:0] fifo_ptr_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Word-align a fetch target; the low two bits are never honoured.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Prefetch FIFO of fetch entries; flush empties it in one cycle.
module if_fifo
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  fetch_entry_t             wdata_i,
    output fetch_entry_t             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, wr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= wdata_i;
                wr_q        <= wr_q + PTR_W'(1);
            end
            if (pop_i) rd_q <= rd_q + PTR_W'(1);
            cnt_q <= cnt_d;
        end
    end

    assign rdata_o = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign count_o = cnt_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: fetch PC, prefetch FIFO and decode handshake.
// Define IF_BYPASS_EN for a zero-latency path from the ROM when the FIFO is empty.
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] inst_addr_o,
    input  logic [31:0] inst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        id_ready_i,
    output logic        id_valid_o,
    output logic [31:0] id_inst_o,
    output logic [31:0] id_pc_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic             pop, fetch_adv, bypass, bypass_take;
    logic [CNT_W-1:0] fifo_count_unused;
    fetch_entry_t     fifo_wdata, fifo_rdata;

`ifdef IF_BYPASS_EN
    assign bypass = fifo_empty & ~redirect_i & ~rst;
`else
    assign bypass = 1'b0;
`endif

    // Handshake, push arbitration and next fetch PC.
    always_comb begin
        pop         = id_valid_o & id_ready_i;
        bypass_take = bypass & id_ready_i;
        fetch_adv   = ~redirect_i & (~fifo_full | pop);
        fifo_push   = fetch_adv & ~bypass_take;
        fifo_pop    = pop & ~fifo_empty;
        fifo_wdata  = '{pc: fetch_pc_q, inst: inst_i};
        fetch_pc_d  = fetch_pc_q;
        if (redirect_i)     fetch_pc_d = align_pc(redirect_pc_i);
        else if (fetch_adv) fetch_pc_d = fetch_pc_q + 32'd4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fetch_pc_q <= RESET_PC;
        else     fetch_pc_q <= fetch_pc_d;
    end

    if_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (redirect_i),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count_unused)
    );

    assign inst_addr_o = fetch_pc_q;

`ifdef IF_BYPASS_EN
    always_comb begin
        id_valid_o = ~fifo_empty | bypass;
        id_inst_o  = '0;
        id_pc_o    = '0;
        if (~fifo_empty) begin
            id_inst_o = fifo_rdata.inst;
            id_pc_o   = fifo_rdata.pc;
        end else if (bypass) begin
            id_inst_o = inst_i;
            id_pc_o   = fetch_pc_q;
        end
    end
`else
    // Registered path only; an empty FIFO presents zeros.
    always_comb begin
        id_valid_o = ~fifo_empty;
        id_inst_o  = fifo_empty ? 32'd0 : fifo_rdata.inst;
        id_pc_o    = fifo_empty ? 32'd0 : fifo_rdata.pc;
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage against a queue-based fetch model.
module tb_if_stage;
    import if_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int          DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_addr_o, inst_i, redirect_pc_i, id_inst_o, id_pc_o;
    logic        redirect_i, id_ready_i, id_valid_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ment_t;

    ment_t       mq[$];
    logic [31:0] mpc;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .inst_addr_o   (inst_addr_o),
        .inst_i        (inst_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .id_ready_i    (id_ready_i),
        .id_valid_o    (id_valid_o),
        .id_inst_o     (id_inst_o),
        .id_pc_o       (id_pc_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    assign inst_i = rom(inst_addr_o);

    function automatic bit bypass_build();
`ifdef IF_BYPASS_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // One cycle: drive inputs, check outputs at negedge, advance the model.
    task automatic step(input logic redir, input logic [31:0] rpc, input logic rdy, input string tag);
        logic        ev;
        logic [31:0] epc, einst;
        int          sz;
        bit          pop, push;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        id_ready_i    = rdy;
        @(negedge clk);
        sz    = mq.size();
        ev    = (sz > 0) || (bypass_build() && !redir);
        epc   = (sz > 0) ? mq[0].pc   : (ev ? mpc : 32'd0);
        einst = (sz > 0) ? mq[0].inst : (ev ? rom(mpc) : 32'd0);
        n_checks++;
        if (inst_addr_o !== mpc) begin
            n_fail++; $display("FAIL %s inst_addr_o: got %h expected %h", tag, inst_addr_o, mpc);
        end
        n_checks++;
        if (id_valid_o !== ev) begin
            n_fail++; $display("FAIL %s id_valid_o: got %b expected %b", tag, id_valid_o, ev);
        end
        n_checks++;
        if (id_pc_o !== epc) begin
            n_fail++; $display("FAIL %s id_pc_o: got %h expected %h", tag, id_pc_o, epc);
        end
        n_checks++;
        if (id_inst_o !== einst) begin
            n_fail++; $display("FAIL %s id_inst_o: got %h expected %h", tag, id_inst_o, einst);
        end
        pop = ev && rdy;
        if (redir) begin
            mq.delete();
            mpc = {rpc[31:2], 2'b00};
        end else begin
            push = (sz < DEPTH) || pop;
            if (pop && sz > 0) void'(mq.pop_front());
            if (push) begin
                if (!(pop && sz == 0)) mq.push_back('{pc: mpc, inst: rom(mpc)});
                mpc = mpc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        mpc = RST_PC;
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; id_ready_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; id_ready_i = 1'b1;
        #1;
        n_checks++;
        if (id_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset id_valid_o: got %b expected 0", id_valid_o); end
        n_checks++;
        if (id_inst_o !== 32'd0) begin n_fail++; $display("FAIL reset id_inst_o: got %h expected 0", id_inst_o); end
        n_checks++;
        if (id_pc_o !== 32'd0) begin n_fail++; $display("FAIL reset id_pc_o: got %h expected 0", id_pc_o); end
        n_checks++;
        if (inst_addr_o !== RST_PC) begin n_fail++; $display("FAIL reset inst_addr_o: got %h expected %h", inst_addr_o, RST_PC); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, "stream");
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0, "stall");
        n_checks++;
        if (inst_addr_o !== 32'h8000_0010) begin n_fail++; $display("FAIL stall_addr inst_addr_o: got %h expected 80000010", inst_addr_o); end
        n_checks++;
        if (id_pc_o !== 32'h8000_0000) begin n_fail++; $display("FAIL stall_pc id_pc_o: got %h expected 80000000", id_pc_o); end
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, "drain");
    endtask

    task automatic test_full_flow();
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, "fill");
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, "full_flow");
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, "pre_redir");
        step(1'b1, 32'h8000_1003, 1'b0, "redir");
        n_checks++;
        if (inst_addr_o !== 32'h8000_1000) begin n_fail++; $display("FAIL redir_addr inst_addr_o: got %h expected 80001000", inst_addr_o); end
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'($urandom_range(0, 1)), "post_redir");
    endtask

    task automatic test_wrap();
        do_reset();
        step(1'b1, 32'hFFFF_FFF8, 1'b1, "wrap_redir");
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, "wrap");
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b0, "b2b_fill");
        step(1'b1, 32'h1000_0000, 1'b1, "b2b_r1");
        step(1'b1, 32'h2000_0006, 1'b1, "b2b_r2");
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, "b2b");
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b0, "mid_fill");
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (id_valid_o !== 1'b0) begin n_fail++; $display("FAIL midreset id_valid_o: got %b expected 0", id_valid_o); end
        n_checks++;
        if (inst_addr_o !== RST_PC) begin n_fail++; $display("FAIL midreset inst_addr_o: got %h expected %h", inst_addr_o, RST_PC); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, "after_reset");
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic rd, rr;
            rd = ($urandom_range(0, 9) < 6);
            rr = ($urandom_range(0, 19) == 0);
            step(rr, $urandom, rd, "random");
        end
    endtask

    initial begin
        rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; id_ready_i = 1'b0;
        mpc = RST_PC;
        test_reset();
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, "first");
        test_stream();
        test_backpressure();
        test_full_flow();
        test_redirect();
        test_wrap();
        test_back_to_back();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
